mem_responder: RTL and testbench

- Memory-side responder for the multi-cycle control/datapath pair.
- Accepts single-word read and write requests on the readM/writeM request interface and services them from an internal word array after a fixed, parameterised latency.
- Signals completion with a one-cycle `ready` pulse, matching the MEM1/MEM2 and IF1–IF3 multi-cycle access stages on the initiator side.

---
 rtl/mem_responder.sv | 122 ++++++++++++
 tb/tb_mem_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder servicing single-word readM/writeM requests
//   from an internal word array after LATENCY rising edges.
// Ports: clk, reset_n (sync, active-low), readM/writeM/address/data_in request side,
//   data_out/ready/error response side. Build macro MEM_STATS_EN adds the
//   num_reads/num_writes completion counters.
module mem_responder #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 readM,
  input  logic                 writeM,
  input  logic [WORD_SIZE-1:0] address,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 ready,
`ifdef MEM_STATS_EN
  output logic [WORD_SIZE-1:0] num_reads,
  output logic [WORD_SIZE-1:0] num_writes,
`endif
  output logic                 error
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  logic [3:0]             cnt;
  logic                   op_write;
  logic [ADDR_BITS-1:0]   lat_addr;
  logic [WORD_SIZE-1:0]   lat_data;
  logic [WORD_SIZE-1:0]   mem [0:DEPTH-1];
  logic                   complete;

  // Upper address bits are deliberately dropped: addresses alias modulo depth.
  logic unused_addr_hi;
  assign unused_addr_hi = ^address[WORD_SIZE-1:ADDR_BITS];

  // The access happens on the edge where the BUSY countdown has reached zero.
  assign complete = (state == BUSY) && (cnt == 4'd0);

  // Array is never cleared; reset only blocks an in-flight write.
  always_ff @(posedge clk) begin
    if (reset_n && complete && op_write) begin
      mem[lat_addr] <= lat_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      data_out <= '0;
      ready    <= 1'b0;
      error    <= 1'b0;
      cnt      <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          error <= 1'b0;
          if (readM ^ writeM) begin
            op_write <= writeM;
            lat_addr <= address[ADDR_BITS-1:0];
            lat_data <= data_in;
            cnt      <= CNT_INIT;
            state    <= BUSY;
          end else if (readM && writeM) begin
            // Conflicting request: flag it and park in DONE until both drop.
            error <= 1'b1;
            state <= DONE;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!op_write) begin
              data_out <= mem[lat_addr];
            end
            ready <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          ready <= 1'b0;
          error <= 1'b0;
          // Wait for the initiator to drop its request so it is not serviced twice.
          if (!readM && !writeM) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      num_reads  <= '0;
      num_writes <= '0;
    end else if (complete) begin
      if (op_write) begin
        num_writes <= num_writes + 1'b1;
      end else begin
        num_reads <= num_reads + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  typedef struct {
    int          dut;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        rd   [2];
  logic        wr   [2];
  logic [15:0] addr [2];
  logic [15:0] din  [2];
  logic [15:0] dout [2];
  logic        rdy  [2];
  logic        err  [2];
`ifdef MEM_STATS_EN
  logic [15:0] nrd  [2];
  logic [15:0] nwr  [2];
`endif

  int   cyc;
  int   checks;
  int   fails;
  int   lat [2];
  int   m_reads [2];
  int   m_writes [2];
  exp_t sb[$];
  exp_t err_q[$];

  mem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .readM(rd[0]), .writeM(wr[0]),
    .address(addr[0]), .data_in(din[0]), .data_out(dout[0]), .ready(rdy[0]),
`ifdef MEM_STATS_EN
    .num_reads(nrd[0]), .num_writes(nwr[0]),
`endif
    .error(err[0])
  );

  mem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .readM(rd[1]), .writeM(wr[1]),
    .address(addr[1]), .data_in(din[1]), .data_out(dout[1]), .ready(rdy[1]),
`ifdef MEM_STATS_EN
    .num_reads(nrd[1]), .num_writes(nwr[1]),
`endif
    .error(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every ready/error pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (rdy[d] === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_ready dut%0d cyc=%0d data_out=%h required=no ready", d, cyc, dout[d]);
        end else begin
          e = sb.pop_front();
          if (e.dut != d || e.data !== dout[d] || e.cyc != cyc) begin
            fails++;
            $display("FAIL ready_rsp dut%0d got data_out=%h cyc=%0d required dut%0d data_out=%h cyc=%0d",
                     d, dout[d], cyc, e.dut, e.data, e.cyc);
          end
        end
      end
      if (err[d] === 1'b1) begin
        checks++;
        if (err_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_error dut%0d cyc=%0d required=no error", d, cyc);
        end else begin
          e = err_q.pop_front();
          if (e.dut != d || e.cyc != cyc) begin
            fails++;
            $display("FAIL error_pulse dut%0d got cyc=%0d required dut%0d cyc=%0d", d, cyc, e.dut, e.cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req_v);
    checks++;
    if (act !== req_v) begin
      fails++;
      $display("FAIL %s got=%h required=%h", name, act, req_v);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      m_reads[d]  = 0;
      m_writes[d] = 0;
    end
    reset_n = 1'b1;
  endtask

  // Issue one request, hold until the response (plus 'hold' extra cycles), then drop it.
  // a_late replaces the address one cycle after acceptance (latched value must win).
  task automatic req(input int d, input bit r, input bit w, input logic [15:0] a,
                     input logic [15:0] a_late, input logic [15:0] di,
                     input logic [15:0] exp_dout, input int hold);
    exp_t e;
    bit   seen;
    @(negedge clk);
    rd[d] = r; wr[d] = w; addr[d] = a; din[d] = di;
    e.dut  = d;
    e.data = exp_dout;
    if (r && w) begin
      e.cyc = cyc + 1;
      err_q.push_back(e);
    end else begin
      e.cyc = cyc + 1 + lat[d];
      sb.push_back(e);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (i == 0) begin
        addr[d] = a_late;
        din[d]  = ~di;
      end
      seen = (r && w) ? (err[d] === 1'b1) : (rdy[d] === 1'b1);
    end
    if (!seen) begin
      checks++;
      fails++;
      $display("FAIL timeout dut%0d addr=%h got=no response required=response within 20 cycles", d, a);
    end else if (!(r && w)) begin
      if (r) m_reads[d]++;
      else   m_writes[d]++;
    end
    repeat (hold) @(negedge clk);
    rd[d] = 1'b0;
    wr[d] = 1'b0;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    lat[0] = 2;
    lat[1] = 1;
    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; din[d] = '0;
      m_reads[d] = 0; m_writes[d] = 0;
    end
    do_reset();

    // Reset state
    chk("rst_data_out", dout[0], 16'h0000);
    chk("rst_ready",    {15'h0, rdy[0]}, 16'h0000);
    chk("rst_error",    {15'h0, err[0]}, 16'h0000);

    // Basic write then read; a write leaves data_out untouched
    req(0, 0, 1, 16'h0005, 16'h0005, 16'h1234, 16'h0000, 0);
    req(0, 1, 0, 16'h0005, 16'h0005, 16'h0000, 16'h1234, 0);

    // Held read: exactly one ready pulse over 10 held cycles
    req(0, 0, 1, 16'h0003, 16'h0003, 16'h3333, 16'h1234, 0);
    req(0, 1, 0, 16'h0003, 16'h0003, 16'h0000, 16'h3333, 8);

    // Conflicting request: error pulse only, array untouched
    req(0, 0, 1, 16'h0020, 16'h0020, 16'h7777, 16'h3333, 0);
    req(0, 1, 1, 16'h0020, 16'h0020, 16'h1111, 16'h0000, 3);
    req(0, 1, 0, 16'h0020, 16'h0020, 16'h0000, 16'h7777, 0);

    // Address aliasing above ADDR_BITS
    req(0, 0, 1, 16'h0107, 16'h0107, 16'hBEEF, 16'h7777, 0);
    req(0, 1, 0, 16'h0007, 16'h0007, 16'h0000, 16'hBEEF, 0);

    // Reset aborts an in-flight write
    req(0, 0, 1, 16'h0010, 16'h0010, 16'h5555, 16'hBEEF, 0);
    req(0, 1, 0, 16'h0010, 16'h0010, 16'h0000, 16'h5555, 0);
    @(negedge clk);
    wr[0] = 1'b1; addr[0] = 16'h0010; din[0] = 16'hAAAA;
    @(negedge clk);                     // accepted on the edge just passed
    reset_n = 1'b0;
    wr[0]   = 1'b0;
    @(negedge clk);                     // reset edge lands one edge before completion
    chk("abort_data_out", dout[0], 16'h0000);
    chk("abort_ready",    {15'h0, rdy[0]}, 16'h0000);
    chk("abort_error",    {15'h0, err[0]}, 16'h0000);
    for (int d = 0; d < 2; d++) begin
      m_reads[d]  = 0;
      m_writes[d] = 0;
    end
    reset_n = 1'b1;
    req(0, 1, 0, 16'h0010, 16'h0010, 16'h0000, 16'h5555, 0);

    // LATENCY=1 instance, address changed right after acceptance
    req(1, 0, 1, 16'h0001, 16'h0001, 16'h00C1, 16'h0000, 0);
    req(1, 0, 1, 16'h0002, 16'h0002, 16'h00C2, 16'h0000, 0);
    req(1, 1, 0, 16'h0001, 16'h0002, 16'h0000, 16'h00C1, 0);
    req(1, 1, 0, 16'h0102, 16'h0001, 16'h0000, 16'h00C2, 0);

    repeat (4) @(negedge clk);

`ifdef MEM_STATS_EN
    for (int d = 0; d < 2; d++) begin
      chk("num_reads",  nrd[d], 16'(m_reads[d]));
      chk("num_writes", nwr[d], 16'(m_writes[d]));
    end
`endif

    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL missing_ready got=%0d outstanding required=0", sb.size());
    end
    checks++;
    if (err_q.size() != 0) begin
      fails++;
      $display("FAIL missing_error got=%0d outstanding required=0", err_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
